// File: rtl/psum_acc_mem.sv
// ---------------------------------------------------------------------------
// psum_acc_mem
//   Partial-sum accumulation memory. Each word holds `col` signed lanes of
//   `psum_bw` bits. Commands (WRITE / ACC / READ / CLEAR) are accepted one
//   per cycle and flow through a 2-stage pipeline:
//     S1 : synchronous array read of the target word
//     S2 : lane-wise compute (saturating add or pass-through), write-back,
//          READ result registration (with optional per-lane ReLU)
//   CLEAR drains the pipeline and then sweeps zeros over the whole array,
//   one word per cycle, with cmd_ready held low.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   cmd_valid  : command present
//   cmd_ready  : command accepted when cmd_valid & cmd_ready at a rising edge
//   cmd_op     : 00 WRITE, 01 ACC, 10 READ, 11 CLEAR
//   cmd_addr   : target word address (ignored for CLEAR)
//   cmd_data   : lane-packed data, lane i = [psum_bw*(i+1)-1 : psum_bw*i]
//   relu_en    : sampled with READ; clamps negative lanes to 0 on readout
//   rd_valid   : one-cycle pulse marking a new rd_data
//   rd_data    : READ result, held until the next READ result
//   busy       : any pipeline stage valid, or draining / clearing
// ---------------------------------------------------------------------------
module psum_acc_mem #(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_width = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [addr_width-1:0]   cmd_addr,
  input  logic [psum_bw*col-1:0]  cmd_data,
  input  logic                    relu_en,
  output logic                    rd_valid,
  output logic [psum_bw*col-1:0]  rd_data,
  output logic                    busy
);

  // state    | meaning
  // ---------+-----------------------------------------------------------
  // ST_IDLE  | pipeline empty, waiting for a command
  // ST_RUN   | commands in flight, still accepting one per cycle
  // ST_DRAIN | CLEAR accepted, letting in-flight S1/S2 ops finish
  // ST_CLEAR | writing zero to addresses 0..DEPTH-1, one per cycle

  localparam int DW    = psum_bw * col;
  localparam int DEPTH = 1 << addr_width;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_ACC   = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [psum_bw-1:0]    LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0]    LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [addr_width-1:0] ADDR_LAST = {addr_width{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic accept, accept_pipe, accept_clr;

  // S1 stage
  logic                  s1_valid;
  logic [1:0]            s1_op;
  logic [addr_width-1:0] s1_addr;
  logic [DW-1:0]         s1_data;
  logic                  s1_relu;

  // S2 stage
  logic                  s2_valid;
  logic [1:0]            s2_op;
  logic [addr_width-1:0] s2_addr;
  logic [DW-1:0]         s2_data;
  logic                  s2_relu;

  // Array and its registered read port
  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         rd_q;

  // Last S2 write, kept one cycle for forwarding
  logic                  wb_valid;
  logic [addr_width-1:0] wb_addr;
  logic [DW-1:0]         wb_data;

  logic [addr_width-1:0] clr_addr;
  logic                  clr_we;

  logic [DW-1:0]         s2_old;
  logic [DW-1:0]         acc_sum;
  logic [DW-1:0]         relu_data;
  logic                  s2_we;
  logic [DW-1:0]         s2_wdata;

  logic [psum_bw-1:0]    lane_a, lane_b, lane_s;
  logic [psum_bw:0]      lane_sum;

  assign accept      = cmd_valid & cmd_ready;
  assign accept_pipe = accept & (cmd_op != OP_CLEAR);
  assign accept_clr  = accept & (cmd_op == OP_CLEAR);
  assign clr_we      = (state == ST_CLEAR);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_clr)       state_nxt = ST_DRAIN;
        else if (accept_pipe) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (accept_clr)
          state_nxt = ST_DRAIN;
        else if (!accept_pipe && !s1_valid && !s2_valid)
          state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        // Nothing enters S1 while draining; whatever sits in S2 writes back
        // at this edge, ahead of the first zero write.
        if (!s1_valid) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_addr == ADDR_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
    busy      = s1_valid || s2_valid || (state == ST_DRAIN) || (state == ST_CLEAR);
  end

  // -------------------------------------------------------------------------
  // Clear sweep address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 clr_addr <= '0;
    else if (state == ST_CLEAR) clr_addr <= clr_addr + addr_width'(1);
    else                        clr_addr <= '0;
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_WRITE;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_relu  <= 1'b0;
      s2_valid <= 1'b0;
      s2_op    <= OP_WRITE;
      s2_addr  <= '0;
      s2_data  <= '0;
      s2_relu  <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= accept_pipe;
      if (accept_pipe) begin
        s1_op   <= cmd_op;
        s1_addr <= cmd_addr;
        s1_data <= cmd_data;
        s1_relu <= relu_en;
      end

      s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_addr  <= s1_addr;
      s2_data  <= s1_data;
      s2_relu  <= s1_relu;

      wb_valid <= s2_we;
      wb_addr  <= s2_addr;
      wb_data  <= s2_wdata;

      rd_valid <= s2_valid && (s2_op == OP_READ);
      if (s2_valid && (s2_op == OP_READ)) rd_data <= relu_data;
    end
  end

  // -------------------------------------------------------------------------
  // Array: not reset. The read in S1 samples the array before any write at
  // the same edge lands, so the S2 compute takes the previous write-back
  // when the addresses match.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= '0;
    else if (s2_we) mem[s2_addr]  <= s2_wdata;
    rd_q <= mem[s1_addr];
  end

  // -------------------------------------------------------------------------
  // S2 datapath
  // -------------------------------------------------------------------------
  always_comb begin
    s2_old    = (wb_valid && (wb_addr == s2_addr)) ? wb_data : rd_q;
    acc_sum   = '0;
    relu_data = '0;
    lane_a    = '0;
    lane_b    = '0;
    lane_s    = '0;
    lane_sum  = '0;
    for (int i = 0; i < col; i++) begin
      lane_a   = s2_old[i*psum_bw +: psum_bw];
      lane_b   = s2_data[i*psum_bw +: psum_bw];
      lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
      // Sign bit and extra carry disagree only on overflow of this lane.
      if (lane_sum[psum_bw] != lane_sum[psum_bw-1])
        lane_s = lane_sum[psum_bw] ? LANE_MIN : LANE_MAX;
      else
        lane_s = lane_sum[psum_bw-1:0];
      acc_sum[i*psum_bw +: psum_bw]   = lane_s;
      relu_data[i*psum_bw +: psum_bw] = (s2_relu && lane_a[psum_bw-1]) ? '0 : lane_a;
    end
  end

  assign s2_we    = s2_valid && ((s2_op == OP_WRITE) || (s2_op == OP_ACC));
  assign s2_wdata = (s2_op == OP_WRITE) ? s2_data : acc_sum;

endmodule

// File: tb/tb_psum_acc_mem.sv
module tb_psum_acc_mem;

  localparam int COL   = 8;
  localparam int PW    = 16;
  localparam int AW    = 11;
  localparam int DW    = COL * PW;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_A = 2'b01;
  localparam logic [1:0] OP_R = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          relu_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;

  psum_acc_mem #(.col(COL), .psum_bw(PW), .addr_width(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .relu_en   (relu_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: sequential semantics, every accepted command applied
  // in order; READ results are due two edges after acceptance.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  int   model [DEPTH][COL];
  bit   known [DEPTH];
  exp_t q [$];
  int   cyc      = 0;
  int   last_acc = -10;
  bit   clearing = 1'b0;
  int   low_cnt  = 0;
  int   n_vec    = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [DW-1:0] d, input int i);
    logic signed [PW-1:0] t;
    t = d[i*PW +: PW];
    return int'(t);
  endfunction

  function automatic logic [DW-1:0] model_word(input int a, input bit relu);
    logic [DW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      v = model[a][i];
      if (relu && v < 0) v = 0;
      r[i*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] two(input int l0, input int rest);
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PW +: PW] = (i == 0) ? l0[PW-1:0] : rest[PW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    return two(v, v);
  endfunction

  function automatic logic [DW-1:0] alt(input int ev, input int od);
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PW +: PW] = (i % 2 == 0) ? ev[PW-1:0] : od[PW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PW +: PW] = PW'($urandom);
    return r;
  endfunction

  task automatic apply(input logic [1:0] op, input int a, input logic [DW-1:0] d, input bit relu);
    int s;
    exp_t e;
    case (op)
      OP_W: begin
        for (int i = 0; i < COL; i++) model[a][i] = lane(d, i);
        known[a] = 1'b1;
      end
      OP_A: begin
        for (int i = 0; i < COL; i++) begin
          s = model[a][i] + lane(d, i);
          if (s > 32767)  s = 32767;
          if (s < -32768) s = -32768;
          model[a][i] = s;
        end
      end
      OP_R: begin
        e.due  = cyc + 2;
        e.data = model_word(a, relu);
        q.push_back(e);
      end
      default: begin
        for (int k = 0; k < DEPTH; k++) begin
          for (int i = 0; i < COL; i++) model[k][i] = 0;
          known[k] = 1'b1;
        end
        clearing = 1'b1;
        low_cnt  = 0;
      end
    endcase
    if (op != OP_C) last_acc = cyc;
  endtask

  // One clock: drive, take the edge, then check outputs 1 time unit later.
  task automatic step(input bit v, input logic [1:0] op, input int a,
                      input logic [DW-1:0] d, input bit relu);
    bit acc;
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = a[AW-1:0];
    cmd_data  = d;
    relu_en   = relu;
    acc = v && (cmd_ready === 1'b1);
    @(posedge clk);
    cyc++;
    if (acc) apply(op, a, d, relu);
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rd_valid_pulse", {{(DW-1){1'b0}}, rd_valid}, 1);
      chk("rd_data", rd_data, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("rd_valid_quiet", {{(DW-1){1'b0}}, rd_valid}, 0);
    end
    if (clearing) begin
      if (cmd_ready === 1'b1) begin
        clearing = 1'b0;
        chk("clear_length", {{(DW-1){1'b0}}, (low_cnt >= DEPTH && low_cnt <= DEPTH + 2)}, 1);
      end else begin
        low_cnt++;
        chk("busy_clearing", {{(DW-1){1'b0}}, busy}, 1);
      end
    end else begin
      chk("cmd_ready", {{(DW-1){1'b0}}, cmd_ready}, 1);
      chk("busy", {{(DW-1){1'b0}}, busy}, {{(DW-1){1'b0}}, ((cyc - last_acc) <= 1)});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, OP_W, 0, '0, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},    {{(DW-1){1'b0}}, cmd_ready}, 1);
    chk({tag, "_busy"},     {{(DW-1){1'b0}}, busy}, 0);
    chk({tag, "_rd_valid"}, {{(DW-1){1'b0}}, rd_valid}, 0);
    chk({tag, "_rd_data"},  rd_data, 0);
  endtask

  initial begin
    int guard;
    int a;
    logic [1:0] op;

    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_W;
    cmd_addr  = '0;
    cmd_data  = '0;
    relu_en   = 1'b0;
    #12;
    reset_checks("reset");
    reset = 1'b1;

    // Back-to-back WRITE / ACC / READ on one address
    step(1'b1, OP_W, 3, fill(100), 1'b0);
    step(1'b1, OP_A, 3, fill(-30), 1'b0);
    step(1'b1, OP_R, 3, '0, 1'b0);
    idle(3);

    // Lane saturation at both rails, neighbouring lanes untouched
    step(1'b1, OP_W, 10, two(32760, 11), 1'b0);
    step(1'b1, OP_A, 10, two(20, 0), 1'b0);
    step(1'b1, OP_R, 10, '0, 1'b0);
    step(1'b1, OP_W, 11, two(-32760, -11), 1'b0);
    step(1'b1, OP_A, 11, two(-20, 0), 1'b0);
    step(1'b1, OP_R, 11, '0, 1'b0);
    idle(3);

    // ReLU on readout only
    step(1'b1, OP_W, 12, alt(-5, 5), 1'b0);
    step(1'b1, OP_R, 12, '0, 1'b1);
    step(1'b1, OP_R, 12, '0, 1'b0);
    idle(3);

    // Four back-to-back ACC +1
    step(1'b1, OP_W, 7, fill(0), 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, OP_A, 7, fill(1), 1'b0);
    step(1'b1, OP_R, 7, '0, 1'b0);
    idle(3);

    // CLEAR right behind a READ; junk commands held while not ready
    step(1'b1, OP_R, 3, '0, 1'b0);
    step(1'b1, OP_C, 0, '0, 1'b0);
    guard = 0;
    while (clearing && guard < DEPTH + 10) begin
      step(1'b1, OP_W, 5, rnd_data(), 1'b0);
      guard++;
    end
    chk("clear_done", {{(DW-1){1'b0}}, clearing}, 0);
    step(1'b1, OP_R, 5, '0, 1'b0);
    step(1'b1, OP_R, 3, '0, 1'b1);
    step(1'b1, OP_R, 7, '0, 1'b0);
    idle(3);

    // Random traffic over a small address window to exercise forwarding
    for (int k = 0; k < 600; k++) begin
      a  = int'($urandom_range(0, 7));
      op = 2'($urandom_range(0, 2));
      if (!known[a]) op = OP_W;
      step(($urandom_range(0, 9) < 8), op, a, rnd_data(), 1'($urandom_range(0, 1)));
    end
    idle(4);
    chk("rd_queue_empty", DW'(q.size()), 0);

    // Reset in the middle of a CLEAR sweep
    step(1'b1, OP_C, 0, '0, 1'b0);
    idle(101);
    reset = 1'b0;
    #1;
    reset_checks("async_reset");
    @(posedge clk);
    #1;
    reset_checks("reset_held");
    reset    = 1'b1;
    clearing = 1'b0;
    q.delete();
    last_acc = -10;
    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
    step(1'b1, OP_W, 9, fill(42), 1'b0);
    step(1'b1, OP_R, 9, '0, 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_acc_mem.md
PSUM_ACC_MEM -- requirements
Module: psum_acc_mem

Interface
REQ-001 SHALL have parameter col, default 8, meaning output channels per memory word.
REQ-002 SHALL have parameter psum_bw, default 16, meaning signed bits per channel lane.
REQ-003 SHALL have parameter addr_width, default 11, meaning address bits; DEPTH = 2^addr_width words.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 SHALL have port cmd_op  input  2  operation: 00 WRITE, 01 ACC, 10 READ, 11 CLEAR.
REQ-009 SHALL have port cmd_addr  input  addr_width  target word address; ignored for CLEAR.
REQ-010 SHALL have port cmd_data  input  psum_bw*col  lane-packed data; lane i is bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-011 SHALL have port relu_en  input  1  sampled with READ commands; clamps negative lanes to 0 on readout.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse marking valid rd_data.
REQ-013 SHALL have port rd_data  output  psum_bw*col  READ result, held until the next READ result.
REQ-014 SHALL have port busy  output  1  high while any command is in flight or CLEAR is sweeping.

Function
REQ-015 SHALL process accepted commands through a 2-stage pipeline: S1 issues the synchronous array read, S2 computes and writes.
REQ-016 SHALL hold cmd_ready high in idle and run states, so back-to-back commands are accepted at one per cycle.
REQ-017 SHALL, for WRITE accepted at edge T, store cmd_data at cmd_addr at edge T+2.
REQ-018 SHALL, for ACC accepted at edge T, store the per-lane signed saturating sum old+cmd_data at edge T+2.
REQ-019 SHALL saturate each lane independently to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; no carry crosses lanes.
REQ-020 SHALL, for READ accepted at edge T, register rd_data at edge T+2, with rd_valid high for the cycle following that edge.
REQ-021 SHALL apply ReLU per lane to rd_data only, never to stored contents, and only when the READ's relu_en was 1.
REQ-022 SHALL make every READ/ACC observe all earlier accepted WRITE/ACC results, including back-to-back same-address commands.
REQ-023 SHALL implement REQ-022 by forwarding from the S2 write (and the previous S2 write) on address match, with no stall.
REQ-024 SHALL implement FSM states IDLE, RUN, DRAIN and CLEAR.
REQ-025 SHALL transition IDLE->RUN on an accepted non-CLEAR command, and RUN->IDLE when the pipeline is empty with no new accept.
REQ-026 SHALL, on an accepted CLEAR, enter DRAIN, drop cmd_ready from the next cycle, and let in-flight S1/S2 ops complete.
REQ-027 SHALL enter CLEAR after DRAIN and write zero to addresses 0..DEPTH-1, one per cycle in ascending order.
REQ-028 SHALL, after address DEPTH-1 is written, go to IDLE and raise cmd_ready in the following cycle.
REQ-029 SHALL have CLEAR take DEPTH cycles plus at most 2 drain cycles.
REQ-030 SHALL drive busy high when any pipeline stage is valid or the state is DRAIN/CLEAR, and low otherwise.
REQ-031 SHALL ignore cmd_* while cmd_ready is low and SHALL NOT latch or queue such commands.
REQ-032 SHALL leave memory contents undefined after reset until a CLEAR or explicit WRITEs; the block SHALL NOT reset the array.

Reset
REQ-033 SHALL, on reset low, asynchronously force state to IDLE, cmd_ready to 1, and rd_valid, busy and rd_data to 0.
REQ-034 SHALL clear all pipeline valids and forwarding registers during reset.
REQ-035 SHALL abort an in-progress CLEAR or pipeline op on reset; partially cleared contents are undefined.
REQ-036 SHALL, after reset deassertion, accept a command at the first rising edge.

Verification
REQ-037 SHALL cover: CLEAR, then READ addr 5 -> cmd_ready low for 2048+drain cycles, then rd_data all lanes 0.
REQ-038 SHALL cover: WRITE addr 3 = all lanes 100, then ACC addr 3 +(-30) back-to-back, then READ addr 3 -> all lanes 70 exactly 2 cycles after the READ accept.
REQ-039 SHALL cover: WRITE lane0 = 32760, then ACC +20 -> READ gives 32767; WRITE -32760, then ACC -20 -> READ gives -32768; other lanes unaffected.
REQ-040 SHALL cover: WRITE lanes alternating -5/+5, then READ with relu_en=1 -> 0/5, then READ with relu_en=0 -> -5/5.
REQ-041 SHALL cover: 4 consecutive ACC of +1 to addr 7 after WRITE 0 -> READ gives 4, with no stall cycles.
REQ-042 SHALL cover: reset low during CLEAR at address 100 -> next cycle cmd_ready=1, busy=0, rd_valid=0.
